// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
//   Shared definitions for the instruction-fetch queue:
//     - default address/data widths and the default reset PC
//     - ifq_entry_t : one queued fetch result {pc, data} at default widths
//     - ifq_ptr_w() : index width of a DEPTH-entry queue
// ----------------------------------------------------------------------------
package ifq_pkg;

  localparam int unsigned IFQ_ADDR_W = 32;
  localparam int unsigned IFQ_DATA_W = 32;

  localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] data;
  } ifq_entry_t;

  // Index width of a DEPTH-entry queue (IFQ_PTR_W).
  function automatic int unsigned ifq_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
//   Synchronous-write, combinational-read FIFO. Pointers carry one extra wrap
//   bit so that full (wrap bits differ) and empty (pointers equal) are
//   distinguishable. clear empties the queue and overrides push/pop.
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   push, wdata    write wdata at the tail
//   pop            drop the head (ignored when empty)
//   clear          empty the queue
//   rdata          head entry (combinational)
//   empty          no entries held
//   count          number of entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  parameter int unsigned  WIDTH = 64,
  localparam int unsigned PTR_W = ifq_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // it was written, and the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch front end between the core and instruction memory.
//   Issues sequential fetches, buffers returned words with their PCs in a
//   DEPTH-entry queue and hands them to the core over valid/ready. A redirect
//   flushes the queue and the in-flight fetch and restarts at redirect_pc.
//   Memory latency is a fixed single cycle; at most one fetch is in flight.
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   redirect_valid, redirect_pc flush and restart fetch (low PC bits ignored)
//   imem_ren, imem_addr         memory read request / address
//   imem_rdata                  read data, valid the cycle after imem_ren
//   inst_valid, inst_data,      queue head (data/pc forced to 0 when invalid)
//   inst_pc, inst_ready         core accepts the head when valid & ready
//   stat_fetch_cnt,             saturating statistics, present only when
//   stat_stall_cnt              the IFQ_STATS_EN macro is defined
// ----------------------------------------------------------------------------
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFQ_ADDR_W,
  parameter int unsigned       DATA_W   = IFQ_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC),
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_ren,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]       stat_fetch_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  localparam int unsigned       PTR_W      = ifq_ptr_w(DEPTH);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [PTR_W:0]    fifo_count;
  logic [PTR_W+1:0]  credits_used;
  logic              fifo_empty;
  logic              fetch_req;
  logic              push, pop;
  entry_t            push_entry, head_entry;

  // Credits: queued entries plus the fetch still in flight. Issuing only while
  // credits remain guarantees a response always finds a free slot, even when
  // nothing is popped in the cycle it arrives.
  assign credits_used = {1'b0, fifo_count} + (PTR_W+2)'(inflight_q);

  // rst gates the request so imem_ren drops the instant reset asserts, not at
  // the next edge.
  assign fetch_req = rst & ~redirect_valid & (credits_used < (PTR_W+2)'(DEPTH));

  assign imem_ren  = fetch_req;
  assign imem_addr = fetch_pc_q;

  // The response of a fetch killed by a redirect is simply not pushed.
  assign push       = inflight_q & ~redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, data: imem_rdata};

  assign inst_valid = ~fifo_empty;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = inst_valid ? head_entry.data : '0;
  assign inst_pc    = inst_valid ? head_entry.pc   : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (fetch_req) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= fetch_req;
      inflight_pc_q <= fetch_pc_q;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .clear (redirect_valid),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_req && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (inst_valid && !inst_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//   Self-checking bench for ifetch_queue (DEPTH=4, PC_STEP=4, RESET_PC=0).
//   A one-cycle ROM returns word == address. A negedge monitor keeps a
//   scoreboard of issued-but-undelivered fetches: requests push, handshakes
//   pop and compare, redirects and reset flush. Directed sequences cover
//   reset, streaming, back-pressure, redirect corner cases, PC wrap and
//   mid-stream reset. Stat ports are checked when IFQ_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hBAD0_BAD0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  exp_t        sb[$];
  logic        inflight_tb = 1'b0;
  logic [31:0] exp_fetch_pc = 32'h0;
  int          issued = 0;
  int          delivered = 0;
  int          stalls = 0;

  ifetch_queue #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ren       (imem_ren),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IFQ_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a;
  endfunction

  // One-cycle-latency instruction memory; garbage when not read.
  always @(posedge clk) imem_rdata <= imem_ren ? rom(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor: inputs change just after posedge, so negedge values
  // are exactly what the DUT acts on at the next posedge.
  always @(negedge clk) begin
    logic exp_ren, exp_valid;
    if (!rst) begin
      check("rst_ren",   imem_ren,   1'b0);
      check("rst_addr",  imem_addr,  32'h0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_data",  inst_data,  32'h0);
      check("rst_pc",    inst_pc,    32'h0);
      sb.delete();
      inflight_tb  = 1'b0;
      exp_fetch_pc = 32'h0;
    end else begin
      exp_ren   = !redirect_valid && (sb.size() < DEPTH);
      exp_valid = (sb.size() > (inflight_tb ? 1 : 0));
      check("mon_ren",   imem_ren,   exp_ren);
      check("mon_valid", inst_valid, exp_valid);
      if (inst_valid && exp_valid) begin
        check("mon_pc",   inst_pc,   sb[0].pc);
        check("mon_data", inst_data, sb[0].data);
      end
      if (!inst_valid) begin
        check("mon_pc_zero",   inst_pc,   32'h0);
        check("mon_data_zero", inst_data, 32'h0);
      end
      if (inst_valid && !inst_ready) stalls++;
      if (inst_valid && inst_ready && exp_valid) begin
        void'(sb.pop_front());
        delivered++;
      end
      if (redirect_valid) begin
        sb.delete();
        inflight_tb  = 1'b0;
        exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (imem_ren) begin
        check("mon_addr", imem_addr, exp_fetch_pc);
        sb.push_back('{pc: exp_fetch_pc, data: rom(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        inflight_tb  = 1'b1;
        issued++;
      end else begin
        inflight_tb = 1'b0;
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ren(input string tag);
    for (int i = 0; i < 50; i++) begin
      sample();
      if (imem_ren) return;
    end
    check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      sample();
      if (inst_valid) return;
    end
    check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input logic ready);
    drive_edge();
    rst        = 1'b0;
    inst_ready = ready;
    repeat (3) drive_edge();
    rst = 1'b1;
  endtask

  initial begin
    int          issued_base, stall_base, deliv_r;
    logic [31:0] got_pcs[$];

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;

    // Reset values while held in reset.
    repeat (5) @(posedge clk);
    sample();
    check("reset_ren",   imem_ren,   1'b0);
    check("reset_addr",  imem_addr,  32'h0);
    check("reset_valid", inst_valid, 1'b0);

    // 1: streaming with ready held high.
    drive_edge();
    rst = 1'b1;
    wait_ren("t1_first_ren");
    check("t1_addr0",  imem_addr,  32'h0);
    check("t1_valid0", inst_valid, 1'b0);
    sample();
    check("t1_addr1",  imem_addr,  32'h4);
    check("t1_valid1", inst_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t1_valid", inst_valid, 1'b1);
      check("t1_pc",    inst_pc,    32'(4 * i));
      check("t1_data",  inst_data,  32'(4 * i));
    end

    // 2: back-pressure from the start.
    do_reset(1'b0);
    issued_base = issued;
    stall_base  = stalls;
    repeat (10) sample();
    check("t2_issued",  32'(issued - issued_base), 32'd4);
    check("t2_ren_off", imem_ren,   1'b0);
    check("t2_head_pc", inst_pc,    32'h0);
    drive_edge();
    inst_ready = 1'b1;
    wait_ren("t2_resume");
    check("t2_resume_addr", imem_addr, 32'h10);
`ifdef IFQ_STATS_EN
    check("t2_stat_stall", stat_stall_cnt, 32'(stalls - stall_base));
    check("t2_stat_fetch", stat_fetch_cnt, 32'(issued - issued_base) - 32'(imem_ren));
`endif
    repeat (6) sample();

    // 3: redirect with every credit used (3 queued + 1 in flight).
    do_reset(1'b0);
    wait_ren("t3_first_ren");
    repeat (4) drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    sample();
    check("t3_r_ren",   imem_ren,   1'b0);
    check("t3_r_valid", inst_valid, 1'b1);
    drive_edge();
    redirect_valid = 1'b0;
    sample();
    check("t3_r1_valid", inst_valid, 1'b0);
    check("t3_r1_ren",   imem_ren,   1'b1);
    check("t3_r1_addr",  imem_addr,  32'h100);
    drive_edge();
    inst_ready = 1'b1;
    wait_valid("t3_first");
    check("t3_first_pc", inst_pc, 32'h100);
    repeat (5) sample();

    // 4: redirect coincident with a pop and an arriving response; low PC
    // bits of the target are ignored.
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    sample();
    check("t4_r_pop",      inst_valid & inst_ready, 1'b1);
    deliv_r = delivered;
    drive_edge();
    redirect_valid = 1'b0;
    sample();
    check("t4_r1_valid", inst_valid, 1'b0);
    check("t4_once",     32'(delivered), 32'(deliv_r));
    sample();
    check("t4_r2_valid", inst_valid, 1'b0);
    sample();
    check("t4_r3_valid", inst_valid, 1'b1);
    check("t4_r3_pc",    inst_pc,    32'h200);

    // Back-to-back redirects: the last one wins.
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    drive_edge();
    redirect_pc    = 32'h404;
    drive_edge();
    redirect_valid = 1'b0;
    wait_valid("t7_first");
    check("t7_first_pc", inst_pc, 32'h404);

    // 5: PC wraps past the top of the address space.
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    drive_edge();
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && got_pcs.size() < 3; i++) begin
      sample();
      if (inst_valid && inst_ready) got_pcs.push_back(inst_pc);
    end
    check("t5_count", 32'(got_pcs.size()), 32'd3);
    if (got_pcs.size() == 3) begin
      check("t5_pc0", got_pcs[0], 32'hFFFF_FFF8);
      check("t5_pc1", got_pcs[1], 32'hFFFF_FFFC);
      check("t5_pc2", got_pcs[2], 32'h0000_0000);
    end

    // 6: asynchronous reset asserted between edges mid-stream.
    repeat (3) sample();
    @(posedge clk);
    #3;
    check("t6_pre_valid", inst_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_valid_drop", inst_valid, 1'b0);
    check("t6_ren_drop",   imem_ren,   1'b0);
`ifdef IFQ_STATS_EN
    check("t6_stat_clr", stat_fetch_cnt, 32'h0);
`endif
    repeat (2) drive_edge();
    rst = 1'b1;
    wait_ren("t6_restart");
    check("t6_restart_addr", imem_addr, 32'h0);
    wait_valid("t6_first");
    check("t6_first_pc", inst_pc, 32'h0);
    repeat (4) sample();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
